mtimer: RTL and testbench

- Memory-mapped RISC-V machine timer on the single-cycle core's data-memory path.
- Consumes the data-side access the core produces: ALU result as address, rs2 as write data, plus mem_read/mem_write.
- Produces the `mtimeData` load value for write-back and the machine timer interrupt level (MTIP) for the CSR/trap logic.
- Reads are combinational, so a load completes in the same cycle. Writes commit on the clk edge.

---
 rtl/mtimer.sv | 163 ++++++++++++++++
 tb/tb_mtimer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mtimer.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime/mtimecmp with prescaler,
// byte-strobed writes, coherent HI snapshot and registered MTIP level.
module mtimer #(
  parameter int unsigned PRESCALE     = 1,
  parameter logic        RESET_ENABLE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [4:0]  address,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic [31:0] read_data,
  output logic        irq_timer,
  output logic        access_err
);

  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);

  localparam logic [2:0] IDX_MTIME_LO = 3'd0;
  localparam logic [2:0] IDX_MTIME_HI = 3'd1;
  localparam logic [2:0] IDX_CMP_LO   = 3'd2;
  localparam logic [2:0] IDX_CMP_HI   = 3'd3;
  localparam logic [2:0] IDX_CTRL     = 3'd4;
  localparam logic [2:0] IDX_SNAP     = 3'd5;

  logic [63:0] mtime_r;
  logic [63:0] mtimecmp_r;
  logic        enable_r;
  logic [15:0] pre_cnt_r;
  logic [31:0] snap_r;
  logic        irq_r;

  logic [63:0] mtime_nxt_s;
  logic [63:0] mtimecmp_nxt_s;
  logic        enable_nxt_s;
  logic [15:0] pre_cnt_nxt_s;
  logic [31:0] snap_nxt_s;
  logic [31:0] read_data_s;
  logic [2:0]  idx_s;
  logic        wr_s;
  logic        rd_s;
  logic        mapped_s;
  logic        tick_s;
  logic        addr_unused_s;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_v;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        res[8*i +: 8] = new_v[8*i +: 8];
      end else begin
        res[8*i +: 8] = old_v[8*i +: 8];
      end
    end
    return res;
  endfunction

  assign idx_s         = address[4:2];
  assign addr_unused_s = ^address[1:0];
  assign wr_s          = sel & mem_write;
  assign rd_s          = sel & mem_read;
  assign mapped_s      = (idx_s <= IDX_SNAP);
  assign tick_s        = enable_r & (pre_cnt_r == PRE_MAX);
  assign access_err    = sel & (mem_read | mem_write) & ~mapped_s;
  assign read_data     = read_data_s;
  assign irq_timer     = irq_r;

  // Next-state for prescaler, counter, compare, control and snapshot.
  always_comb begin
    mtime_nxt_s    = mtime_r;
    mtimecmp_nxt_s = mtimecmp_r;
    enable_nxt_s   = enable_r;
    pre_cnt_nxt_s  = pre_cnt_r;
    snap_nxt_s     = snap_r;

    if (!enable_r) begin
      pre_cnt_nxt_s = pre_cnt_r;
    end else if (tick_s) begin
      pre_cnt_nxt_s = 16'd0;
    end else begin
      pre_cnt_nxt_s = pre_cnt_r + 16'd1;
    end

    // An mtime write in a tick cycle swallows that tick entirely.
    if (wr_s && (idx_s == IDX_MTIME_LO)) begin
      mtime_nxt_s = {mtime_r[63:32], merge_bytes(mtime_r[31:0], write_data, byte_en)};
    end else if (wr_s && (idx_s == IDX_MTIME_HI)) begin
      mtime_nxt_s = {merge_bytes(mtime_r[63:32], write_data, byte_en), mtime_r[31:0]};
    end else if (tick_s) begin
      mtime_nxt_s = mtime_r + 64'd1;
    end else begin
      mtime_nxt_s = mtime_r;
    end

    if (wr_s) begin
      case (idx_s)
        IDX_CMP_LO: mtimecmp_nxt_s[31:0]  = merge_bytes(mtimecmp_r[31:0], write_data, byte_en);
        IDX_CMP_HI: mtimecmp_nxt_s[63:32] = merge_bytes(mtimecmp_r[63:32], write_data, byte_en);
        IDX_CTRL: begin
          if (byte_en[0]) begin
            enable_nxt_s = write_data[0];
          end else begin
            enable_nxt_s = enable_r;
          end
        end
        default: mtimecmp_nxt_s = mtimecmp_r;
      endcase
    end else begin
      mtimecmp_nxt_s = mtimecmp_r;
    end

    // Reading LO freezes the pre-edge HI so LO-then-SNAP is coherent.
    if (rd_s && (idx_s == IDX_MTIME_LO)) begin
      snap_nxt_s = mtime_r[63:32];
    end else begin
      snap_nxt_s = snap_r;
    end
  end

  // Combinational load mux; unmapped or unselected reads return zero.
  always_comb begin
    read_data_s = 32'd0;
    if (rd_s) begin
      case (idx_s)
        IDX_MTIME_LO: read_data_s = mtime_r[31:0];
        IDX_MTIME_HI: read_data_s = mtime_r[63:32];
        IDX_CMP_LO:   read_data_s = mtimecmp_r[31:0];
        IDX_CMP_HI:   read_data_s = mtimecmp_r[63:32];
        IDX_CTRL:     read_data_s = {31'd0, enable_r};
        IDX_SNAP:     read_data_s = snap_r;
        default:      read_data_s = 32'd0;
      endcase
    end else begin
      read_data_s = 32'd0;
    end
  end

  // State registers; the interrupt compares post-update values.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_r    <= 64'd0;
      mtimecmp_r <= 64'hFFFF_FFFF_FFFF_FFFF;
      enable_r   <= RESET_ENABLE;
      pre_cnt_r  <= 16'd0;
      snap_r     <= 32'd0;
      irq_r      <= 1'b0;
    end else begin
      mtime_r    <= mtime_nxt_s;
      mtimecmp_r <= mtimecmp_nxt_s;
      enable_r   <= enable_nxt_s;
      pre_cnt_r  <= pre_cnt_nxt_s;
      snap_r     <= snap_nxt_s;
      irq_r      <= (mtime_nxt_s >= mtimecmp_nxt_s);
    end
  end

endmodule

// File: tb/tb_mtimer.sv
// Directed bench for mtimer: PRESCALE=4 and PRESCALE=1 instances on a shared bus.
module tb_mtimer;

  logic        clk;
  logic        rst;
  logic        sel4;
  logic        sel1;
  logic        mem_read;
  logic        mem_write;
  logic [4:0]  address;
  logic [31:0] write_data;
  logic [3:0]  byte_en;
  logic [31:0] rdata4;
  logic [31:0] rdata1;
  logic        irq4;
  logic        irq1;
  logic        err4;
  logic        err1;

  int total;
  int bad;

  typedef struct {
    logic        sel;
    logic        rd;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[16];

  mtimer #(.PRESCALE(4), .RESET_ENABLE(1'b1)) dut4 (
    .clk(clk), .rst(rst), .sel(sel4), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .read_data(rdata4), .irq_timer(irq4), .access_err(err4)
  );

  mtimer #(.PRESCALE(1), .RESET_ENABLE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sel(sel1), .mem_read(mem_read), .mem_write(mem_write),
    .address(address), .write_data(write_data), .byte_en(byte_en),
    .read_data(rdata1), .irq_timer(irq1), .access_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_bus(input logic s4, input logic s1, input logic rd, input logic wr,
                         input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    sel4 = s4; sel1 = s1; mem_read = rd; mem_write = wr;
    address = a; write_data = d; byte_en = be;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] d, input logic [3:0] be);
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, a, d, be);
    cyc();
  endtask

  task automatic rd_chk(input bit use1, input logic [4:0] a, input logic [31:0] exp,
                        input string name);
    set_bus(!use1, use1, 1'b1, 1'b0, a, 32'd0, 4'd0);
    #1;
    chk(name, use1 ? rdata1 : rdata4, exp);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    // sel rd wr addr wdata be | exp_rd exp_err exp_irq  (dut4 frozen at mtime=10)
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 5'h00, 32'd0,          4'h0, 32'd10,         1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 5'h04, 32'd0,          4'h0, 32'd0,          1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 5'h0C, 32'd0,          4'h0, 32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 5'h10, 32'd0,          4'h0, 32'd0,          1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 5'h18, 32'd0,          4'h0, 32'd0,          1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 5'h1C, 32'hAAAA_AAAA,  4'hF, 32'd0,          1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b1, 5'h00, 32'hDEAD_BEEF,  4'hF, 32'd0,          1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 5'h00, 32'd0,          4'h0, 32'd10,         1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 5'h14, 32'd5,          4'hF, 32'd0,          1'b0, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 5'h14, 32'd0,          4'h0, 32'd0,          1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 5'h10, 32'hFFFF_FFFE,  4'hF, 32'd0,          1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 5'h10, 32'd0,          4'h0, 32'd0,          1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 5'h08, 32'h1234_5678,  4'h5, 32'hFFFF_FFFF,  1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 5'h08, 32'd0,          4'h0, 32'hFF34_FF78,  1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 5'h00, 32'h0000_0077,  4'h1, 32'd10,         1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 5'h00, 32'd0,          4'h0, 32'h0000_0077,  1'b0, 1'b0};

    rst = 1'b1;
    set_bus(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 4'd0);
    cyc();
    rst = 1'b0;

    rd_chk(1'b0, 5'h00, 32'd0, "rst_mtime_lo");
    rd_chk(1'b0, 5'h04, 32'd0, "rst_mtime_hi");
    rd_chk(1'b0, 5'h0C, 32'hFFFF_FFFF, "rst_cmp_hi");
    rd_chk(1'b0, 5'h10, 32'd1, "rst_ctrl");
    chk("rst_irq4", {31'd0, irq4}, 32'd0);
    chk("rst_irq1", {31'd0, irq1}, 32'd0);

    // Prescale 4: 40 edges after reset give 10 ticks, then disable and hold.
    repeat (40) cyc();
    rd_chk(1'b0, 5'h00, 32'd10, "presc_count");
    set_bus(1'b1, 1'b0, 1'b0, 1'b1, 5'h10, 32'd0, 4'hF);
    cyc();
    repeat (20) cyc();
    rd_chk(1'b0, 5'h00, 32'd10, "presc_hold");

    for (int i = 0; i < 16; i++) begin
      set_bus(vecs[i].sel, 1'b0, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata4, vecs[i].exp_rd);
      chk($sformatf("vec%0d_err", i), {31'd0, err4}, {31'd0, vecs[i].exp_err});
      chk($sformatf("vec%0d_irq", i), {31'd0, irq4}, {31'd0, vecs[i].exp_irq});
      cyc();
    end

    // Carry into HI and LO-then-SNAP coherence on the PRESCALE=1 instance.
    wr1(5'h00, 32'hFFFF_FFFE, 4'hF);
    wr1(5'h04, 32'd5, 4'hF);
    repeat (3) cyc();
    rd_chk(1'b1, 5'h00, 32'd1, "carry_lo");
    cyc();
    rd_chk(1'b1, 5'h14, 32'd6, "carry_snap");
    repeat (10) cyc();
    rd_chk(1'b1, 5'h04, 32'd6, "carry_hi");

    // Interrupt rise at mtime==cmp and fall on raising cmp.
    wr1(5'h04, 32'd0, 4'hF);
    wr1(5'h00, 32'd0, 4'hF);
    wr1(5'h0C, 32'd0, 4'hF);
    wr1(5'h08, 32'd20, 4'hF);
    repeat (17) cyc();
    rd_chk(1'b1, 5'h00, 32'd19, "irq_pre_lo");
    chk("irq_pre", {31'd0, irq1}, 32'd0);
    cyc();
    rd_chk(1'b1, 5'h00, 32'd20, "irq_at_lo");
    chk("irq_rise", {31'd0, irq1}, 32'd1);
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 5'h08, 32'd100, 4'hF);
    #1;
    chk("irq_hold_wcycle", {31'd0, irq1}, 32'd1);
    cyc();
    chk("irq_fall", {31'd0, irq1}, 32'd0);
    rd_chk(1'b1, 5'h00, 32'd21, "irq_post_lo");

    // Write/tick collisions with byte strobes.
    set_bus(1'b0, 1'b1, 1'b1, 1'b1, 5'h00, 32'h1234_5678, 4'b0011);
    #1;
    chk("rw_old_value", rdata1, 32'd21);
    cyc();
    rd_chk(1'b1, 5'h00, 32'h0000_5678, "coll_partial");
    cyc();
    wr1(5'h00, 32'h0000_0000, 4'hF);
    rd_chk(1'b1, 5'h00, 32'd0, "coll_full");
    cyc();
    rd_chk(1'b1, 5'h00, 32'd1, "coll_resume");
    rd_chk(1'b1, 5'h04, 32'd0, "coll_hi");

    // 64-bit wrap, with irq tracking the post-update compare.
    wr1(5'h04, 32'hFFFF_FFFF, 4'hF);
    wr1(5'h00, 32'hFFFF_FFFE, 4'hF);
    rd_chk(1'b1, 5'h00, 32'hFFFF_FFFE, "wrap_lo0");
    chk("wrap_irq_hi", {31'd0, irq1}, 32'd1);
    cyc();
    rd_chk(1'b1, 5'h00, 32'hFFFF_FFFF, "wrap_lo1");
    cyc();
    rd_chk(1'b1, 5'h00, 32'd0, "wrap_lo2");
    rd_chk(1'b1, 5'h04, 32'd0, "wrap_hi2");
    chk("wrap_irq_lo", {31'd0, irq1}, 32'd0);

    // Reset beats a simultaneous write.
    rst = 1'b1;
    set_bus(1'b0, 1'b1, 1'b0, 1'b1, 5'h0C, 32'd55, 4'hF);
    cyc();
    rst = 1'b0;
    rd_chk(1'b1, 5'h0C, 32'hFFFF_FFFF, "rst_over_write");
    rd_chk(1'b1, 5'h00, 32'd0, "rst_over_lo");
    rd_chk(1'b1, 5'h10, 32'd1, "rst_over_ctrl");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
